// File: rtl/counter_timer_arbiter_if.sv
// Bus between requesting control FSMs and the shared interval counter.
// Optional pause input exists only when CNT_PAUSE_EN is defined.
interface counter_timer_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] len;
    logic [NREQ-1:0]       grant;
    logic [WIDTH-1:0]      count;
    logic                  busy;
    logic [NREQ-1:0]       done;
`ifdef CNT_PAUSE_EN
    logic                  pause;

    modport master (output req, len, pause, input grant, count, busy, done);
    modport slave  (input req, len, pause, output grant, count, busy, done);
`else
    modport master (output req, len, input grant, count, busy, done);
    modport slave  (input req, len, output grant, count, busy, done);
`endif
endinterface

// File: rtl/counter_timer_arbiter.sv
// Round-robin arbiter sharing one up-counter among NREQ interval requesters.
// Optional feature macro: CNT_PAUSE_EN (adds bus.pause to hold the count).
module counter_timer_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input logic                    clk,
    input logic                    rst,
    counter_timer_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef logic [IW-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    idx_t             owner_q, owner_d;
    idx_t             last_q, last_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] len_q, len_d;

    logic             found;
    idx_t             sel;
    int unsigned      idx;
    logic [NREQ-1:0]  owner_onehot;

    // Cyclic search starting one past the previous winner.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last_q) + k) % NREQ;
            if (!found && bus.req[idx_t'(idx)]) begin
                found = 1'b1;
                sel   = idx_t'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        count_d = count_q;
        len_d   = len_q;
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (found) begin
                    state_d = COUNT;
                    owner_d = sel;
                    last_d  = sel;
                    len_d   = bus.len[32'(sel)*WIDTH +: WIDTH];
                end
            end
            COUNT: begin
                // Abandon outranks pause and the terminal compare.
                if (!bus.req[owner_q]) begin
                    state_d = IDLE;
                    count_d = '0;
                end
`ifdef CNT_PAUSE_EN
                else if (bus.pause) begin
                    count_d = count_q;
                end
`endif
                else if (count_q == len_q) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                count_d = '0;
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= idx_t'(NREQ - 1);
            count_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        owner_onehot = '0;
        owner_onehot[owner_q] = 1'b1;
        bus.busy  = (state_q != IDLE);
        bus.grant = (state_q != IDLE) ? owner_onehot : '0;
        bus.done  = (state_q == DONE) ? owner_onehot : '0;
        bus.count = count_q;
    end
endmodule
